// File: rtl/mem_chk_pkg.sv
// Shared definitions for the data-memory write checker.
// State encoding and default signature constants for CPU benches.
package mem_chk_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } chk_state_t;

    localparam logic [15:0] DEF_PASS_ADDR  = 16'h0054;
    localparam logic [15:0] DEF_PASS_DATA  = 16'h0007;
    localparam logic [15:0] DEF_FAIL_ADDR  = 16'h0058;
    localparam int          DEF_MAX_CYCLES = 60;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head entry.
// The head holds its last value once the FIFO drains.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + PW'(1);

    // Occupancy and next head; a pop exposes the following entry.
    always_comb begin
        cnt_nxt  = cnt;
        head_nxt = rdata;
        if (do_push && !do_pop)
            cnt_nxt = cnt + CW'(1);
        else if (do_pop && !do_push)
            cnt_nxt = cnt - CW'(1);
        if (do_pop) begin
            if (cnt > CW'(1))
                head_nxt = mem[rd_nxt];
            else if (do_push)
                head_nxt = wdata;
        end else if (empty && do_push) begin
            head_nxt = wdata;
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            rdata  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_nxt;
            cnt   <= cnt_nxt;
            rdata <= head_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Store-port self-check: logs stores, watches the pass/fail
// signature and ends the run on a cycle budget.
module mem_write_checker
    import mem_chk_pkg::*;
#(
    parameter int          DW         = 16,
    parameter int          AW         = 16,
    parameter int          LOG_DEPTH  = 8,
    parameter logic [AW-1:0] PASS_ADDR = AW'(DEF_PASS_ADDR),
    parameter logic [DW-1:0] PASS_DATA = DW'(DEF_PASS_DATA),
    parameter logic [AW-1:0] FAIL_ADDR = AW'(DEF_FAIL_ADDR),
    parameter int          MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] writedata,
    input  logic [AW-1:0] dataadr,
    input  logic          memwrite,
    input  logic          log_rd,
    output logic          log_valid,
    output logic [AW-1:0] log_addr,
    output logic [DW-1:0] log_data,
    output logic          log_overflow,
    output logic [15:0]   store_count,
    output logic [15:0]   cycle_count,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout
);

    localparam logic [15:0] LAST = 16'(MAX_CYCLES - 1);

    chk_state_t         state;
    chk_state_t         state_nxt;
    logic               push;
    logic               cyc_inc;
    logic               log_empty;
    logic               log_full;
    logic [AW+DW-1:0]   head;

    sync_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (log_rd),
        .wdata ({dataadr, writedata}),
        .rdata (head),
        .empty (log_empty),
        .full  (log_full)
    );

    assign log_valid = !log_empty;
    assign log_addr  = head[DW +: AW];
    assign log_data  = head[DW-1:0];

    // Next state: signature store beats FAIL_ADDR beats budget expiry.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        cyc_inc   = 1'b0;
        unique case (state)
            ST_RUN: begin
                push = memwrite;
                if (memwrite && dataadr == PASS_ADDR)
                    state_nxt = (writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
                else if (memwrite && dataadr == FAIL_ADDR)
                    state_nxt = ST_FAIL;
                else if (cycle_count == LAST)
                    state_nxt = ST_TIMEOUT;
                else
                    cyc_inc = 1'b1;
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: ;
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register plus registered verdict flags and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            log_overflow <= 1'b0;
            store_count  <= '0;
            cycle_count  <= '0;
        end else begin
            state   <= state_nxt;
            pass    <= (state_nxt == ST_PASS);
            fail    <= (state_nxt == ST_FAIL);
            timeout <= (state_nxt == ST_TIMEOUT);
            done    <= (state_nxt != ST_RUN);
            if (push && log_full && !log_rd)
                log_overflow <= 1'b1;
            if (push && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
            if (cyc_inc)
                cycle_count <= cycle_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a vector table for the
// pass run and hand sequences for fail, timeout, overflow, reset.
module tb_mem_write_checker;

    logic        clk;
    logic        reset;
    logic [15:0] writedata;
    logic [15:0] dataadr;
    logic        memwrite;
    logic        log_rd;
    logic        log_valid;
    logic [15:0] log_addr;
    logic [15:0] log_data;
    logic        log_overflow;
    logic [15:0] store_count;
    logic [15:0] cycle_count;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    mem_write_checker dut (
        .clk          (clk),
        .reset        (reset),
        .writedata    (writedata),
        .dataadr      (dataadr),
        .memwrite     (memwrite),
        .log_rd       (log_rd),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .store_count  (store_count),
        .cycle_count  (cycle_count),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mw;
        logic [15:0] adr;
        logic [15:0] dat;
        logic        rd;
        logic        vld;
        logic [15:0] hadr;
        logic [15:0] hdat;
        logic        ovf;
        logic [15:0] sc;
        logic [15:0] cc;
        logic        dn;
        logic        ps;
        logic        fl;
        logic        to;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic m,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic rd);
        reset     = r;
        memwrite  = m;
        dataadr   = a;
        writedata = d;
        log_rd    = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vld"}, 32'(log_valid), 32'd0);
        chk({tag, ".ovf"}, 32'(log_overflow), 32'd0);
        chk({tag, ".sc"}, 32'(store_count), 32'd0);
        chk({tag, ".cc"}, 32'(cycle_count), 32'd0);
        chk({tag, ".flags"}, {28'd0, done, pass, fail, timeout}, 32'd0);
        chk({tag, ".head"}, {log_addr, log_data}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0;
        writedata = '0; log_rd = 1'b0;

        vt[0]  = '{1,0,16'h0,16'h0,0,    0,16'h0,16'h0,0,   16'd0,16'd0, 0,0,0,0};
        vt[1]  = '{0,1,16'h10,16'h1111,0, 1,16'h10,16'h1111,0, 16'd1,16'd1, 0,0,0,0};
        vt[2]  = '{0,0,16'h0,16'h0,0,    1,16'h10,16'h1111,0, 16'd1,16'd2, 0,0,0,0};
        vt[3]  = '{0,1,16'h12,16'h2222,0, 1,16'h10,16'h1111,0, 16'd2,16'd3, 0,0,0,0};
        vt[4]  = '{0,0,16'h0,16'h0,0,    1,16'h10,16'h1111,0, 16'd2,16'd4, 0,0,0,0};
        vt[5]  = '{0,0,16'h0,16'h0,0,    1,16'h10,16'h1111,0, 16'd2,16'd5, 0,0,0,0};
        vt[6]  = '{0,1,16'h54,16'h7,0,   1,16'h10,16'h1111,0, 16'd3,16'd5, 1,1,0,0};
        vt[7]  = '{0,1,16'h10,16'hAAAA,0, 1,16'h10,16'h1111,0, 16'd3,16'd5, 1,1,0,0};
        vt[8]  = '{0,0,16'h0,16'h0,1,    1,16'h12,16'h2222,0, 16'd3,16'd5, 1,1,0,0};
        vt[9]  = '{0,0,16'h0,16'h0,1,    1,16'h54,16'h7,0,   16'd3,16'd5, 1,1,0,0};
        vt[10] = '{0,0,16'h0,16'h0,1,    0,16'h54,16'h7,0,   16'd3,16'd5, 1,1,0,0};
        vt[11] = '{0,0,16'h0,16'h0,1,    0,16'h54,16'h7,0,   16'd3,16'd5, 1,1,0,0};
        vt[12] = '{1,0,16'h0,16'h0,0,    0,16'h0,16'h0,0,    16'd0,16'd0, 0,0,0,0};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].rst, vt[i].mw, vt[i].adr, vt[i].dat, vt[i].rd);
            chk($sformatf("v%0d.vld", i), 32'(log_valid), 32'(vt[i].vld));
            chk($sformatf("v%0d.head", i), {log_addr, log_data},
                {vt[i].hadr, vt[i].hdat});
            chk($sformatf("v%0d.ovf", i), 32'(log_overflow), 32'(vt[i].ovf));
            chk($sformatf("v%0d.sc", i), 32'(store_count), 32'(vt[i].sc));
            chk($sformatf("v%0d.cc", i), 32'(cycle_count), 32'(vt[i].cc));
            chk($sformatf("v%0d.flags", i),
                {28'd0, done, pass, fail, timeout},
                {28'd0, vt[i].dn, vt[i].ps, vt[i].fl, vt[i].to});
        end

        // wrong signature value
        step(1, 0, 16'h0, 16'h0, 0);
        step(0, 1, 16'h54, 16'h8, 0);
        chk("badsig.flags", {28'd0, done, pass, fail, timeout}, 32'b1010);
        chk("badsig.sc", 32'(store_count), 32'd1);

        // store to the fail address
        step(1, 0, 16'h0, 16'h0, 0);
        idle(1);
        step(0, 1, 16'h58, 16'h1234, 0);
        chk("failadr.flags", {28'd0, done, pass, fail, timeout}, 32'b1010);
        chk("failadr.cc", 32'(cycle_count), 32'd1);

        // budget expiry
        step(1, 0, 16'h0, 16'h0, 0);
        idle(59);
        chk("to.pre.flags", {28'd0, done, pass, fail, timeout}, 32'd0);
        chk("to.pre.cc", 32'(cycle_count), 32'd59);
        idle(1);
        chk("to.flags", {28'd0, done, pass, fail, timeout}, 32'b1001);
        chk("to.cc", 32'(cycle_count), 32'd59);
        idle(3);
        chk("to.frozen.cc", 32'(cycle_count), 32'd59);
        chk("to.frozen.to", 32'(timeout), 32'd1);

        // signature on the last budget cycle wins
        step(1, 0, 16'h0, 16'h0, 0);
        idle(59);
        step(0, 1, 16'h54, 16'h7, 0);
        chk("lastsig.flags", {28'd0, done, pass, fail, timeout}, 32'b1100);
        chk("lastsig.sc", 32'(store_count), 32'd1);
        chk("lastsig.cc", 32'(cycle_count), 32'd59);

        // overflow: 10 stores into an 8-deep log
        step(1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 1, 16'h100 + 16'(i), 16'hA000 + 16'(i), 0);
        chk("ovf.flag", 32'(log_overflow), 32'd1);
        chk("ovf.sc", 32'(store_count), 32'd10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf.pop%0d", i), {log_valid, log_addr, log_data},
                {1'b1, 16'h100 + 16'(i), 16'hA000 + 16'(i)});
            step(0, 0, 16'h0, 16'h0, 1);
        end
        chk("ovf.drained", 32'(log_valid), 32'd0);

        // full log with push and pop on the same edge
        step(1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 8; i++)
            step(0, 1, 16'h200 + 16'(i), 16'hB000 + 16'(i), 0);
        chk("full.ovf0", 32'(log_overflow), 32'd0);
        step(0, 1, 16'h2FF, 16'hBFFF, 1);
        chk("pushpop.ovf", 32'(log_overflow), 32'd0);
        chk("pushpop.sc", 32'(store_count), 32'd9);
        for (int i = 0; i < 8; i++) begin
            if (i < 7)
                chk($sformatf("pp.pop%0d", i), {log_valid, log_addr, log_data},
                    {1'b1, 16'h201 + 16'(i), 16'hB001 + 16'(i)});
            else
                chk("pp.pop7", {log_valid, log_addr, log_data},
                    {1'b1, 16'h2FF, 16'hBFFF});
            step(0, 0, 16'h0, 16'h0, 1);
        end
        chk("pp.drained", 32'(log_valid), 32'd0);

        // reset mid-run at cycle 20
        step(1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 20; i++)
            step(0, (i % 3) == 0, 16'h300 + 16'(i), 16'hC000 + 16'(i), 0);
        chk("mid.cc", 32'(cycle_count), 32'd20);
        chk("mid.sc", 32'(store_count), 32'd7);
        step(1, 0, 16'h0, 16'h0, 0);
        chk_zero("midrst");
        idle(1);
        chk("restart.cc", 32'(cycle_count), 32'd1);
        chk("restart.vld", 32'(log_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
